raster_pos_tracker: RTL

- Pixel-stream stage directly upstream of the Sobel window/line-buffer logic.
- Accepts a raster-ordered pixel stream over a valid/ready handshake and re-emits each pixel one cycle later, tagged with column, row and frame-boundary flags.
- Flags window_valid_o when a full 3x3 neighbourhood ending at the current pixel exists.
- Column and row positions are kept in two instances of the team's up/down/load counter.

---
 rtl/sobel_pkg.sv | 17 +
 rtl/counter.sv | 37 +++
 rtl/raster_pos_tracker.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared constants and tag types for the Sobel pixel pipeline
package sobel_pkg;

  localparam int WIN_K   = 3;
  localparam int WIN_OFF = WIN_K - 1;

  // Position-independent part of a pixel tag; the sized col/row fields are
  // added by each stage, since package types cannot take module parameters.
  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
    logic win;
  } pix_flags_t;

endpackage

// File: rtl/counter.sv
// rtl/counter.sv - up/down counter with synchronous load and optional saturation
module counter #(
  parameter int W_P        = 8,
  parameter int SATURATE_P = 0
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           en_i,
  input  logic           up_i,
  input  logic           load_i,
  input  logic [W_P-1:0] load_val_i,
  output logic [W_P-1:0] cnt_o
);

  logic [W_P-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        if (!(SATURATE_P != 0 && cnt_q == '1)) cnt_d = cnt_q + W_P'(1);
      end else begin
        if (!(SATURATE_P != 0 && cnt_q == '0)) cnt_d = cnt_q - W_P'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/raster_pos_tracker.sv
// rtl/raster_pos_tracker.sv - tags a raster pixel stream with position, frame
// boundary and 3x3-window flags, one register stage, valid/ready handshake
module raster_pos_tracker
  import sobel_pkg::*;
#(
  parameter int DATA_W_P = 8,
  parameter int IMG_W_P  = 640,
  parameter int IMG_H_P  = 480,
  parameter int COL_W_P  = $clog2(IMG_W_P),
  parameter int ROW_W_P  = $clog2(IMG_H_P)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                clear_i,
  input  logic [DATA_W_P-1:0] data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [DATA_W_P-1:0] data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [COL_W_P-1:0]  col_o,
  output logic [ROW_W_P-1:0]  row_o,
  output logic                sol_o,
  output logic                eol_o,
  output logic                sof_o,
  output logic                eof_o,
  output logic                window_valid_o,
  output logic [15:0]         frame_cnt_o
);

  typedef struct packed {
    logic [COL_W_P-1:0] col;
    logic [ROW_W_P-1:0] row;
    pix_flags_t         flags;
  } pix_tag_t;

  localparam logic [COL_W_P-1:0] COL_LAST = COL_W_P'(IMG_W_P - 1);
  localparam logic [ROW_W_P-1:0] ROW_LAST = ROW_W_P'(IMG_H_P - 1);
  localparam logic [COL_W_P-1:0] COL_WIN  = COL_W_P'(WIN_OFF);
  localparam logic [ROW_W_P-1:0] ROW_WIN  = ROW_W_P'(WIN_OFF);

  logic [COL_W_P-1:0]  col_cnt;
  logic [ROW_W_P-1:0]  row_cnt;
  logic                accept, col_last, row_last, line_end, frame_end;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                valid_q, valid_d;
  logic [DATA_W_P-1:0] data_q, data_d;
  pix_tag_t            tag_q, tag_d, tag_now;

  assign ready_o   = !clear_i && (!valid_q || ready_i);
  assign accept    = valid_i && ready_o;
  assign col_last  = (col_cnt == COL_LAST);
  assign row_last  = (row_cnt == ROW_LAST);
  assign line_end  = accept && col_last;
  assign frame_end = line_end && row_last;

  // Wraps go through the load path so the counters never pass their terminal value.
  counter #(.W_P(COL_W_P), .SATURATE_P(0)) u_col_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (accept),
    .up_i       (1'b1),
    .load_i     (clear_i || line_end),
    .load_val_i ('0),
    .cnt_o      (col_cnt)
  );

  counter #(.W_P(ROW_W_P), .SATURATE_P(0)) u_row_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .en_i       (line_end),
    .up_i       (1'b1),
    .load_i     (clear_i || frame_end),
    .load_val_i ('0),
    .cnt_o      (row_cnt)
  );

  always_comb begin
    tag_now           = '0;
    tag_now.col       = col_cnt;
    tag_now.row       = row_cnt;
    tag_now.flags.sol = (col_cnt == '0);
    tag_now.flags.eol = col_last;
    tag_now.flags.sof = (col_cnt == '0) && (row_cnt == '0);
    tag_now.flags.eof = col_last && row_last;
    tag_now.flags.win = (row_cnt >= ROW_WIN) && (col_cnt >= COL_WIN);
  end

  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    tag_d       = tag_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_end && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = data_i;
      tag_d   = tag_now;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q     <= 1'b0;
      data_q      <= '0;
      tag_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign valid_o        = valid_q;
  assign data_o         = data_q;
  assign col_o          = tag_q.col;
  assign row_o          = tag_q.row;
  assign sol_o          = tag_q.flags.sol;
  assign eol_o          = tag_q.flags.eol;
  assign sof_o          = tag_q.flags.sof;
  assign eof_o          = tag_q.flags.eof;
  assign window_valid_o = tag_q.flags.win;
  assign frame_cnt_o    = frame_cnt_q;

endmodule
